elevator_request_tracker: RTL and testbench

Request-capture and scheduling stage upstream of the elevator FSM. It edge-detects hall and cabin push-button levels and latches them into pending-request bitmaps. It clears requests when the controller reports a floor as served. On request it runs a one-floor-per-cycle scan that produces `count_up`, `count_down`, `nearest_up` and `nearest_down` for the controller's direction decision.

---
 rtl/elevator_request_tracker.sv | 166 ++++++++++++++++
 tb/tb_elevator_request_tracker.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_request_tracker.sv
// Request capture and scheduling ahead of the elevator FSM: edge-detects buttons,
// latches pending requests, and runs a one-floor-per-cycle scan for direction hints.
module elevator_request_tracker #(
  parameter int FLOOR_COUNT = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [FLOOR_COUNT-1:0] hall_up_btn,
  input  logic [FLOOR_COUNT-1:0] hall_down_btn,
  input  logic [FLOOR_COUNT-1:0] cabin_btn,
  input  logic [31:0]            position,
  input  logic                   serve_valid,
  input  logic                   serve_dir,
  input  logic                   scan_start,
  output logic [FLOOR_COUNT-1:0] hall_up_pending,
  output logic [FLOOR_COUNT-1:0] hall_down_pending,
  output logic [FLOOR_COUNT-1:0] cabin_pending,
  output logic                   busy,
  output logic                   scan_done,
  output logic [7:0]             count_up,
  output logic [7:0]             count_down,
  output logic [7:0]             nearest_up,
  output logic [7:0]             nearest_down
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [7:0] LAST_IDX = 8'(FLOOR_COUNT - 1);
  // Top floor has no "up" hall call and ground floor has no "down" hall call.
  localparam logic [FLOOR_COUNT-1:0] UP_MASK   = {1'b0, {(FLOOR_COUNT-1){1'b1}}};
  localparam logic [FLOOR_COUNT-1:0] DOWN_MASK = {{(FLOOR_COUNT-1){1'b1}}, 1'b0};

  state_t state, next_state;

  logic [FLOOR_COUNT-1:0] hall_up_q, hall_down_q, cabin_q;
  logic [FLOOR_COUNT-1:0] press_up, press_down, press_cabin;
  logic [FLOOR_COUNT-1:0] clr;
  logic [FLOOR_COUNT-1:0] up_next, down_next, cabin_next;
  logic [FLOOR_COUNT-1:0] any;

  logic [31:0]            pos_q;
  logic [FLOOR_COUNT-1:0] snap;
  logic [7:0]             idx;
  logic [7:0]             cnt_up, cnt_down;
  logic [7:0]             near_up, near_down;
  logic                   found_up;
  logic [31:0]            idx_wide;

  assign press_up    = hall_up_btn   & ~hall_up_q   & UP_MASK;
  assign press_down  = hall_down_btn & ~hall_down_q & DOWN_MASK;
  assign press_cabin = cabin_btn     & ~cabin_q;

  // One-hot clear; an out-of-range position simply matches no floor.
  always_comb begin
    clr = '0;
    for (int f = 0; f < FLOOR_COUNT; f++) begin
      clr[f] = serve_valid && (position == 32'(f));
    end
  end

  // Clear first, then OR in new presses so a same-cycle press wins.
  assign up_next    = (hall_up_pending   & ~(clr & {FLOOR_COUNT{serve_dir}}))  | press_up;
  assign down_next  = (hall_down_pending & ~(clr & {FLOOR_COUNT{~serve_dir}})) | press_down;
  assign cabin_next = (cabin_pending     & ~clr) | press_cabin;

  assign any = hall_up_pending | hall_down_pending | cabin_pending;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hall_up_q         <= '0;
      hall_down_q       <= '0;
      cabin_q           <= '0;
      hall_up_pending   <= '0;
      hall_down_pending <= '0;
      cabin_pending     <= '0;
    end else begin
      hall_up_q         <= hall_up_btn;
      hall_down_q       <= hall_down_btn;
      cabin_q           <= cabin_btn;
      hall_up_pending   <= up_next;
      hall_down_pending <= down_next;
      cabin_pending     <= cabin_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (scan_start) next_state = SCAN;
      SCAN:    if (idx == LAST_IDX) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign idx_wide = {24'd0, idx};

  // Scan datapath: snap shifts right so bit 0 is always the floor at idx.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos_q        <= '0;
      snap         <= '0;
      idx          <= '0;
      cnt_up       <= '0;
      cnt_down     <= '0;
      near_up      <= '0;
      near_down    <= '0;
      found_up     <= 1'b0;
      scan_done    <= 1'b0;
      count_up     <= '0;
      count_down   <= '0;
      nearest_up   <= '0;
      nearest_down <= '0;
    end else begin
      scan_done <= 1'b0;
      case (state)
        IDLE: begin
          if (scan_start) begin
            pos_q     <= position;
            snap      <= any;
            idx       <= '0;
            cnt_up    <= '0;
            cnt_down  <= '0;
            near_up   <= '0;
            near_down <= '0;
            found_up  <= 1'b0;
          end
        end
        SCAN: begin
          if (snap[0]) begin
            if (idx_wide > pos_q) begin
              cnt_up <= cnt_up + 8'd1;
              if (!found_up) begin
                near_up  <= idx;
                found_up <= 1'b1;
              end
            end else if (idx_wide < pos_q) begin
              cnt_down  <= cnt_down + 8'd1;
              near_down <= idx;
            end
          end
          snap <= snap >> 1;
          if (idx != LAST_IDX) idx <= idx + 8'd1;
        end
        DONE: begin
          scan_done    <= 1'b1;
          count_up     <= cnt_up;
          count_down   <= cnt_down;
          nearest_up   <= found_up ? near_up : pos_q[7:0];
          nearest_down <= (cnt_down != 8'd0) ? near_down : pos_q[7:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_request_tracker.sv
// Bench for elevator_request_tracker: directed scenarios plus random traffic
// checked every cycle against a floor-by-floor behavioural model.
module tb_elevator_request_tracker;

  localparam int F = 10;

  logic          clock = 1'b0;
  logic          reset;
  logic [F-1:0]  hall_up_btn, hall_down_btn, cabin_btn;
  logic [31:0]   position;
  logic          serve_valid, serve_dir, scan_start;
  logic [F-1:0]  hall_up_pending, hall_down_pending, cabin_pending;
  logic          busy, scan_done;
  logic [7:0]    count_up, count_down, nearest_up, nearest_down;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit [F-1:0] m_hu, m_hd, m_cb, m_hu_q, m_hd_q, m_cb_q;
  int         m_phase;
  bit         m_done;
  int         m_cu, m_cd, m_nu, m_nd;
  int         r_cu, r_cd, r_nu, r_nd;

  elevator_request_tracker #(.FLOOR_COUNT(F)) dut (
    .clock(clock), .reset(reset),
    .hall_up_btn(hall_up_btn), .hall_down_btn(hall_down_btn), .cabin_btn(cabin_btn),
    .position(position), .serve_valid(serve_valid), .serve_dir(serve_dir),
    .scan_start(scan_start),
    .hall_up_pending(hall_up_pending), .hall_down_pending(hall_down_pending),
    .cabin_pending(cabin_pending), .busy(busy), .scan_done(scan_done),
    .count_up(count_up), .count_down(count_down),
    .nearest_up(nearest_up), .nearest_down(nearest_down)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    m_hu = '0; m_hd = '0; m_cb = '0;
    m_hu_q = '0; m_hd_q = '0; m_cb_q = '0;
    m_phase = -1; m_done = 1'b0;
    m_cu = 0; m_cd = 0; m_nu = 0; m_nd = 0;
  endtask

  // Scan result straight from the rules: count and pick nearest floors above/below.
  task automatic computeScan(input bit [F-1:0] req, input logic [31:0] pos);
    bit found;
    found = 1'b0;
    r_cu = 0; r_cd = 0;
    r_nu = int'(pos[7:0]); r_nd = int'(pos[7:0]);
    for (int f = 0; f < F; f++) begin
      if (req[f]) begin
        if (32'(f) > pos) begin
          r_cu++;
          if (!found) begin r_nu = f; found = 1'b1; end
        end else if (32'(f) < pos) begin
          r_cd++;
          r_nd = f;
        end
      end
    end
  endtask

  task automatic modelStep(input bit [F-1:0] hu, hd, cb, input logic [31:0] pos,
                           input bit sv, sd, ss);
    bit [F-1:0] req;
    bit was_busy;
    req = m_hu | m_hd | m_cb;
    was_busy = (m_phase >= 0);
    for (int f = 0; f < F; f++) begin
      if (sv && pos == 32'(f)) begin
        m_cb[f] = 1'b0;
        if (sd) m_hu[f] = 1'b0; else m_hd[f] = 1'b0;
      end
      if (hu[f] && !m_hu_q[f] && f != F-1) m_hu[f] = 1'b1;
      if (hd[f] && !m_hd_q[f] && f != 0)   m_hd[f] = 1'b1;
      if (cb[f] && !m_cb_q[f])             m_cb[f] = 1'b1;
    end
    m_hu_q = hu; m_hd_q = hd; m_cb_q = cb;
    m_done = 1'b0;
    if (was_busy) begin
      m_phase++;
      if (m_phase == F + 1) begin
        m_phase = -1;
        m_done = 1'b1;
        m_cu = r_cu; m_cd = r_cd; m_nu = r_nu; m_nd = r_nd;
      end
    end else if (ss) begin
      m_phase = 0;
      computeScan(req, pos);
    end
  endtask

  task automatic compareAll();
    checkOutput("hu_pend", 32'(hall_up_pending), 32'(m_hu));
    checkOutput("hd_pend", 32'(hall_down_pending), 32'(m_hd));
    checkOutput("cb_pend", 32'(cabin_pending), 32'(m_cb));
    checkOutput("busy", 32'(busy), 32'(m_phase >= 0));
    checkOutput("scan_done", 32'(scan_done), 32'(m_done));
    checkOutput("count_up", 32'(count_up), 32'(m_cu));
    checkOutput("count_down", 32'(count_down), 32'(m_cd));
    checkOutput("nearest_up", 32'(nearest_up), 32'(m_nu));
    checkOutput("nearest_down", 32'(nearest_down), 32'(m_nd));
  endtask

  // Drive one cycle of inputs, step the model at the edge, compare 1 time unit later.
  task automatic applyStimulus(input bit [F-1:0] hu, hd, cb, input logic [31:0] pos,
                               input bit sv, sd, ss);
    hall_up_btn = hu; hall_down_btn = hd; cabin_btn = cb;
    position = pos; serve_valid = sv; serve_dir = sd; scan_start = ss;
    @(posedge clock);
    modelStep(hu, hd, cb, pos, sv, sd, ss);
    #1;
    compareAll();
  endtask

  task automatic doReset();
    hall_up_btn = '0; hall_down_btn = '0; cabin_btn = '0;
    position = '0; serve_valid = 1'b0; serve_dir = 1'b0; scan_start = 1'b0;
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    compareAll();
    @(posedge clock);
    #1;
    reset = 1'b0;
    compareAll();
  endtask

  task automatic runScan(input logic [31:0] pos, output int lat);
    applyStimulus('0, '0, '0, pos, 1'b0, 1'b0, 1'b1);
    lat = 0;
    while (!scan_done && lat < F + 10) begin
      applyStimulus('0, '0, '0, pos, 1'b0, 1'b0, 1'b0);
      lat++;
    end
    checkOutput("scan_latency", 32'(lat), 32'(F + 1));
  endtask

  initial begin
    bit [F-1:0] hu, hd, cb;
    int lat, dones;
    reset = 1'b1;
    doReset();

    // Three hall-up pulses, scan from floor 0, then from floor 6
    foreach (hu[i]) hu[i] = 1'b0;
    applyStimulus(F'(1) << 2, '0, '0, 0, 0, 0, 0);
    applyStimulus(F'(1) << 5, '0, '0, 0, 0, 0, 0);
    applyStimulus(F'(1) << 8, '0, '0, 0, 0, 0, 0);
    applyStimulus('0, '0, '0, 0, 0, 0, 0);
    runScan(0, lat);
    checkOutput("t1_cu", 32'(count_up), 3);
    checkOutput("t1_cd", 32'(count_down), 0);
    checkOutput("t1_nu", 32'(nearest_up), 2);
    checkOutput("t1_nd", 32'(nearest_down), 0);
    runScan(6, lat);
    checkOutput("t2_cu", 32'(count_up), 1);
    checkOutput("t2_cd", 32'(count_down), 2);
    checkOutput("t2_nu", 32'(nearest_up), 8);
    checkOutput("t2_nd", 32'(nearest_down), 5);

    // Held button cleared by a serve does not re-latch until pressed again
    for (int c = 1; c <= 6; c++) begin
      applyStimulus(F'(1) << 3, '0, '0, 3, c == 3, 1'b1, 0);
      if (c == 2) checkOutput("t3_set", 32'(hall_up_pending[3]), 1);
      if (c == 3) checkOutput("t3_clr", 32'(hall_up_pending[3]), 0);
    end
    checkOutput("t3_held", 32'(hall_up_pending[3]), 0);
    applyStimulus('0, '0, '0, 3, 0, 0, 0);
    applyStimulus(F'(1) << 3, '0, '0, 3, 0, 0, 0);
    checkOutput("t3_relatch", 32'(hall_up_pending[3]), 1);

    // Set wins over a same-cycle clear
    applyStimulus('0, '0, F'(1) << 4, 4, 1'b1, 1'b0, 0);
    checkOutput("t4_setwins", 32'(cabin_pending[4]), 1);

    // Ignored end buttons, top-floor request
    doReset();
    applyStimulus(F'(1) << (F-1), F'(1), '0, 0, 0, 0, 0);
    checkOutput("t5_hu_top", 32'(hall_up_pending[F-1]), 0);
    checkOutput("t5_hd_bot", 32'(hall_down_pending[0]), 0);
    applyStimulus('0, '0, F'(1) << 9, 0, 0, 0, 0);
    applyStimulus('0, '0, '0, 0, 0, 0, 0);
    runScan(9, lat);
    checkOutput("t5_cu9", 32'(count_up), 0);
    checkOutput("t5_nu9", 32'(nearest_up), 9);
    checkOutput("t5_cd9", 32'(count_down), 0);
    runScan(3, lat);
    checkOutput("t5_cu3", 32'(count_up), 1);
    checkOutput("t5_nu3", 32'(nearest_up), 9);

    // scan_start during busy is ignored
    dones = 0;
    applyStimulus('0, '0, '0, 2, 0, 0, 1);
    for (int c = 1; c <= 2 * F; c++) begin
      applyStimulus('0, '0, '0, 2, 0, 0, c == 4);
      if (scan_done) dones++;
    end
    checkOutput("t6_one_done", 32'(dones), 1);

    // Reset mid-scan aborts with outputs cleared
    applyStimulus('0, '0, '0, 5, 0, 0, 1);
    for (int c = 1; c <= 4; c++) applyStimulus('0, '0, '0, 5, 0, 0, 0);
    doReset();
    for (int c = 0; c < F + 4; c++) applyStimulus('0, '0, '0, 5, 0, 0, 0);

    // Random traffic against the model
    hu = '0; hd = '0; cb = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int f = 0; f < F; f++) begin
        if ($urandom_range(0, 5) == 0) hu[f] = ~hu[f];
        if ($urandom_range(0, 5) == 0) hd[f] = ~hd[f];
        if ($urandom_range(0, 5) == 0) cb[f] = ~cb[f];
      end
      applyStimulus(hu, hd, cb, 32'($urandom_range(0, 12)),
                    $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 7) == 0);
      if (n == 1500) begin
        doReset();
        hu = '0; hd = '0; cb = '0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
